// File: rtl/rv32e_pkg.sv
// Shared ISA constants, ALU op enum and memory map for the rv32e mini SoC.
package rv32e_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] RAM_BASE    = 32'h0000_1000;
    localparam logic [31:0] IO_IN_ADDR  = 32'h0000_2000;
    localparam logic [31:0] IO_OUT_ADDR = 32'h0000_2004;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    function automatic alu_op_e alu_op_of(input logic [2:0] f3,
                                          input logic sub,
                                          input logic sra);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = sub ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = sra ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32e_alu.sv
// Combinational 32-bit ALU with the comparator flags used by branches.
import rv32e_pkg::*;

module rv32e_alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);

    logic [4:0] shamt;

    assign shamt = b[4:0];
    assign eq    = (a == b);
    assign lt    = ($signed(a) < $signed(b));
    assign ltu   = (a < b);

    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {31'b0, lt};
            ALU_SLTU: result = {31'b0, ltu};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rv32e_mini_soc.sv
// Single-cycle RV32E core with data RAM and 8-bit I/O port.
// Define RV32E_INPUT_SYNC_EN to put a two-flop synchroniser on i.
import rv32e_pkg::*;

module rv32e_mini_soc #(
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] program_addr_bus,
    input  logic [31:0] program_data_bus,
    input  logic [7:0]  i,
    output logic [7:0]  o
);

    localparam int AW = $clog2(DMEM_WORDS);

    logic [31:0] pc;
    logic [31:0] rf  [16];
    logic [31:0] ram [DMEM_WORDS];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4, br_target;

    logic        valid, rd_we, use_rs1, use_rs2, is_store, jump, legal;
    logic [31:0] alu_a, alu_b, alu_y, rd_wdata, target, pc_next;
    alu_op_e     alu_op;
    logic        eq, lt, ltu, taken;

    logic [31:0] mem_addr, rdata, shifted, ld_val, st_data;
    logic [AW-1:0] ram_idx;
    logic [15:0] ld_h;
    logic [3:0]  st_be;
    logic        in_ram, hit_in, hit_out;
    logic        wr_rf, wr_ram, wr_o;
    logic [7:0]  i_val;

    assign program_addr_bus = pc;
    assign instr  = program_data_bus;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    assign rs1_val   = (rs1[3:0] == 4'd0) ? '0 : rf[rs1[3:0]];
    assign rs2_val   = (rs2[3:0] == 4'd0) ? '0 : rf[rs2[3:0]];
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc + ((opcode == OP_JAL) ? imm_j : imm_b);

`ifdef RV32E_INPUT_SYNC_EN
    logic [7:0] i_meta, i_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            i_meta <= '0;
            i_sync <= '0;
        end else begin
            i_meta <= i;
            i_sync <= i_meta;
        end
    end

    assign i_val = i_sync;
`else
    assign i_val = i;
`endif

    rv32e_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_y),
        .eq     (eq),
        .lt     (lt),
        .ltu    (ltu)
    );

    always_comb begin
        taken = 1'b0;
        case (f3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = !lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        valid    = 1'b0;
        rd_we    = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        is_store = 1'b0;
        jump     = 1'b0;
        target   = br_target;
        alu_op   = ALU_ADD;
        alu_a    = rs1_val;
        alu_b    = imm_i;
        rd_wdata = alu_y;
        unique case (1'b1)
            opcode == OP_LUI: begin
                valid = 1'b1;
                rd_we = 1'b1;
                alu_a = '0;
                alu_b = imm_u;
            end
            opcode == OP_AUIPC: begin
                valid = 1'b1;
                rd_we = 1'b1;
                alu_a = pc;
                alu_b = imm_u;
            end
            opcode == OP_JAL: begin
                valid    = 1'b1;
                rd_we    = 1'b1;
                jump     = 1'b1;
                rd_wdata = pc_plus4;
            end
            opcode == OP_JALR: begin
                valid    = (f3 == 3'b000);
                rd_we    = 1'b1;
                use_rs1  = 1'b1;
                jump     = 1'b1;
                target   = alu_y;
                rd_wdata = pc_plus4;
            end
            opcode == OP_BRANCH: begin
                valid   = (f3 != 3'b010) && (f3 != 3'b011);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                alu_b   = rs2_val;
                jump    = taken;
            end
            opcode == OP_LOAD: begin
                valid    = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
                rd_we    = 1'b1;
                use_rs1  = 1'b1;
                rd_wdata = ld_val;
            end
            opcode == OP_STORE: begin
                valid    = f3 inside {F3_SB, F3_SH, F3_SW};
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                is_store = 1'b1;
                alu_b    = imm_s;
            end
            opcode == OP_IMM: begin
                valid   = (f3 == F3_SLL) ? (f7 == F7_BASE) :
                          (f3 == F3_SR)  ? (f7 == F7_BASE || f7 == F7_ALT) :
                          1'b1;
                rd_we   = 1'b1;
                use_rs1 = 1'b1;
                alu_op  = alu_op_of(f3, 1'b0, f7[5]);
            end
            opcode == OP_REG: begin
                valid   = (f7 == F7_BASE) ||
                          (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
                rd_we   = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                alu_b   = rs2_val;
                alu_op  = alu_op_of(f3, f7[5], f7[5]);
            end
            default: ;
        endcase
    end

    // Register indices are only checked in fields the format actually uses.
    assign legal = valid && !(rd_we && rd[4]) &&
                   !(use_rs1 && rs1[4]) && !(use_rs2 && rs2[4]);
    assign pc_next = (legal && jump) ? {target[31:2], 2'b00} : pc_plus4;

    assign mem_addr = alu_y;
    assign ram_idx  = mem_addr[AW+1:2];
    assign in_ram   = (mem_addr[31:8] == RAM_BASE[31:8]);
    assign hit_in   = (mem_addr[31:2] == IO_IN_ADDR[31:2]);
    assign hit_out  = (mem_addr[31:2] == IO_OUT_ADDR[31:2]);

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            in_ram:  rdata = ram[ram_idx];
            hit_in:  rdata = {24'b0, i_val};
            hit_out: rdata = {24'b0, o};
            default: rdata = '0;
        endcase
    end

    assign shifted = rdata >> {mem_addr[1:0], 3'b000};
    assign ld_h    = mem_addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld_val = '0;
        case (f3)
            F3_LB:   ld_val = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   ld_val = {{16{ld_h[15]}}, ld_h};
            F3_LW:   ld_val = rdata;
            F3_LBU:  ld_val = {24'b0, shifted[7:0]};
            F3_LHU:  ld_val = {16'b0, ld_h};
            default: ld_val = '0;
        endcase
    end

    always_comb begin
        st_be   = 4'b0000;
        st_data = rs2_val;
        case (f3)
            F3_SB: begin
                st_be   = 4'b0001 << mem_addr[1:0];
                st_data = {4{rs2_val[7:0]}};
            end
            F3_SH: begin
                st_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{rs2_val[15:0]}};
            end
            F3_SW:   st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    assign wr_rf  = legal && rd_we && (rd[3:0] != 4'd0);
    assign wr_ram = legal && is_store && in_ram;
    assign wr_o   = legal && is_store && hit_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
            o  <= '0;
            for (int k = 0; k < 16; k++) rf[k] <= '0;
        end else begin
            pc <= pc_next;
            if (wr_rf) rf[rd[3:0]] <= rd_wdata;
            if (wr_o)  o <= rs2_val[7:0];
        end
    end

    // RAM is deliberately not cleared by reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && wr_ram) begin
            for (int b = 0; b < 4; b++)
                if (st_be[b]) ram[ram_idx][8*b +: 8] <= st_data[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_rv32e_mini_soc.sv
// Directed program test for rv32e_mini_soc with a combinational ROM model.
module tb_rv32e_mini_soc;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] JALR = 7'b1100111, LOAD = 7'b0000011;
    localparam logic [6:0] OPI = 7'b0010011, OPR = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] program_addr_bus, program_data_bus;
    logic [7:0]  i = 8'h3C;
    logic [7:0]  o;
    logic [31:0] rom [0:63];
    int n_cmp = 0;
    int n_err = 0;

    rv32e_mini_soc dut (
        .clk              (clk),
        .reset            (reset),
        .program_addr_bus (program_addr_bus),
        .program_data_bus (program_data_bus),
        .i                (i),
        .o                (o)
    );

    always #5 clk = ~clk;
    assign program_data_bus = rom[program_addr_bus[7:2]];

    function automatic logic [31:0] enc_r(logic [31:0] f7, logic [31:0] rs2,
        logic [31:0] rs1, logic [31:0] f3, logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPR};
    endfunction

    function automatic logic [31:0] enc_i(logic [31:0] imm, logic [31:0] rs1,
        logic [31:0] f3, logic [31:0] rd, logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_s(logic [31:0] imm, logic [31:0] rs2,
        logic [31:0] rs1, logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(logic [31:0] imm, logic [31:0] rs2,
        logic [31:0] rs1, logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0],
                imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(logic [31:0] imm, logic [31:0] rd,
        logic [6:0] op);
        return {imm[19:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_j(logic [31:0] imm, logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int taken;
        logic [31:0] prev;
        for (int k = 0; k < 64; k++) rom[k] = 32'h0000_0013;
        rom[0]  = enc_i(5, 0, 0, 1, OPI);
        rom[1]  = enc_i(-3, 0, 0, 2, OPI);
        rom[2]  = enc_r(0, 2, 1, 0, 3);
        rom[3]  = enc_r(32, 1, 2, 0, 4);
        rom[4]  = enc_i(32'hA5, 0, 0, 5, OPI);
        rom[5]  = enc_u(2, 6, LUI);
        rom[6]  = enc_s(4, 5, 6, 2);
        rom[7]  = enc_i(4, 6, 4, 7, LOAD);
        rom[8]  = enc_i(-1, 0, 0, 8, OPI);
        rom[9]  = enc_u(1, 9, LUI);
        rom[10] = enc_s(0, 0, 9, 2);
        rom[11] = enc_s(1, 8, 9, 0);
        rom[12] = enc_i(0, 9, 2, 10, LOAD);
        rom[13] = enc_i(1, 9, 0, 11, LOAD);
        rom[14] = enc_i(3, 0, 0, 1, OPI);
        rom[15] = enc_b(8, 0, 1, 1);
        rom[16] = enc_j(12, 0);
        rom[17] = enc_i(-1, 1, 0, 1, OPI);
        rom[18] = enc_j(-12, 0);
        rom[19] = enc_j(8, 1);
        rom[20] = enc_i(32'h77, 0, 0, 14, OPI);
        rom[21] = enc_i(0, 6, 2, 12, LOAD);
        rom[22] = enc_r(0, 1, 1, 0, 16);
        rom[23] = enc_r(0, 1, 1, 0, 17);
        rom[24] = enc_r(0, 0, 17, 0, 3);
        rom[25] = enc_i(32'h401, 4, 5, 15, OPI);
        rom[26] = enc_r(0, 4, 1, 3, 13);
        rom[27] = enc_r(0, 1, 4, 2, 14);
        rom[28] = enc_b(8, 1, 4, 4);
        rom[29] = enc_i(0, 0, 0, 15, OPI);
        rom[30] = enc_b(8, 1, 4, 7);
        rom[31] = enc_i(0, 0, 0, 15, OPI);
        rom[32] = enc_i(0, 9, 1, 13, LOAD);
        rom[33] = enc_u(1, 3, AUIPC);
        rom[34] = enc_i(32'h93, 0, 0, 2, JALR);
        rom[35] = enc_i(0, 0, 0, 15, OPI);
        rom[36] = enc_s(2, 8, 9, 1);
        rom[37] = enc_i(2, 9, 5, 10, LOAD);
        rom[38] = enc_j(0, 0);

        step();
        step();
        reset = 1'b0;
        chk("reset_pc", program_addr_bus, 32'h0);
        chk("reset_o", {24'b0, o}, 32'h0);
        chk("reset_x1", dut.rf[1], 32'h0);

        step();
        chk("pc_step4", program_addr_bus, 32'h4);
        chk("addi_x1", dut.rf[1], 32'd5);
        step();
        chk("pc_step8", program_addr_bus, 32'h8);
        chk("addi_x2", dut.rf[2], 32'hFFFF_FFFD);
        step();
        chk("add_x3", dut.rf[3], 32'h2);
        step();
        chk("sub_x4", dut.rf[4], 32'hFFFF_FFF8);
        step();
        step();
        chk("lui_x6", dut.rf[6], 32'h0000_2000);
        chk("o_before_sw", {24'b0, o}, 32'h0);
        step();
        chk("sw_out", {24'b0, o}, 32'hA5);
        step();
        chk("lbu_out", dut.rf[7], 32'hA5);
        repeat (5) step();
        chk("lw_ram", dut.rf[10], 32'h0000_FF00);
        step();
        chk("lb_ram", dut.rf[11], 32'hFFFF_FFFF);
        step();
        chk("loop_entry", program_addr_bus, 32'h3C);

        taken = 0;
        for (int k = 0; k < 40 && program_addr_bus != 32'h4C; k++) begin
            prev = program_addr_bus;
            step();
            if (prev == 32'h3C && program_addr_bus == 32'h44) taken++;
        end
        chk("loop_exit", program_addr_bus, 32'h4C);
        chk("bne_taken", taken, 32'd3);
        chk("loop_x1", dut.rf[1], 32'h0);

        step();
        chk("jal_pc", program_addr_bus, 32'h54);
        chk("jal_link", dut.rf[1], 32'h50);
        step();
        chk("lw_in", dut.rf[12], 32'h3C);
        chk("jal_skip", dut.rf[14], 32'h0);
        step();
        chk("x16_pc", program_addr_bus, 32'h5C);
        chk("x16_x1", dut.rf[1], 32'h50);
        step();
        chk("x17_x1", dut.rf[1], 32'h50);
        step();
        chk("rs1_x17", dut.rf[3], 32'h2);
        step();
        chk("srai", dut.rf[15], 32'hFFFF_FFFC);
        step();
        chk("sltu", dut.rf[13], 32'h1);
        step();
        chk("slt", dut.rf[14], 32'h1);
        step();
        chk("blt_pc", program_addr_bus, 32'h78);
        step();
        chk("bgeu_pc", program_addr_bus, 32'h80);
        step();
        chk("lh", dut.rf[13], 32'hFFFF_FF00);
        step();
        chk("auipc", dut.rf[3], 32'h0000_1084);
        step();
        chk("jalr_pc", program_addr_bus, 32'h90);
        chk("jalr_link", dut.rf[2], 32'h8C);
        step();
        step();
        chk("sh_lhu", dut.rf[10], 32'h0000_FFFF);
        chk("skips_x15", dut.rf[15], 32'hFFFF_FFFC);
        step();
        step();
        chk("spin_pc", program_addr_bus, 32'h98);

        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rerst_pc", program_addr_bus, 32'h0);
        chk("rerst_o", {24'b0, o}, 32'h0);
        chk("rerst_x3", dut.rf[3], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
